eh2_mpc_hart_ctrl: RTL and testbench
====================================

# eh2_mpc_hart_ctrl

Parametrised multi-hart MPC (multi-processor controller) debug halt/run handshake engine. It sits between the SoC power/debug controller and the eh2 core in the top-level wrapper, and generalises the single-hart MPC port group to NUM_HARTS harts. Per hart it synchronises the asynchronous SoC requests, applies the reset-run strap, drives level halt/run requests into the core, and returns four-phase acknowledges. An optional per-hart watchdog flags a core that fails to respond.

## Interface
Parameters:
- NUM_HARTS, 2, number of harts/threads controlled (≥1).
- SYNC_STAGES, 2, flops in each request synchroniser (≥2).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (≥2; used only with RV_MPC_TIMEOUT_EN).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- mpc_debug_halt_req  in  NUM_HARTS  async level halt request from SoC.
- mpc_debug_run_req  in  NUM_HARTS  async level run request from SoC.
- mpc_reset_run_req  in  NUM_HARTS  quasi-static strap, sampled during rst: 1 = run after reset, 0 = halt after reset.
- core_halted  in  NUM_HARTS  core status, 1 = hart halted.
- core_halt_req  out  NUM_HARTS  level halt request to core.
- core_run_req  out  NUM_HARTS  level run request to core.
- mpc_debug_halt_ack  out  NUM_HARTS  halt acknowledge.
- mpc_debug_run_ack  out  NUM_HARTS  run acknowledge.
- dec_tlu_mhartstart  out  NUM_HARTS  1 while hart state is RUN.
- mpc_timeout_clr  in  NUM_HARTS  pulse, clears sticky timeout flag.
- mpc_timeout_err  out  NUM_HARTS  sticky watchdog error.

## Operation
- Harts are fully independent; identical logic is replicated per hart h.
- halt_req_s and run_req_s are mpc_debug_halt_req/run_req after SYNC_STAGES flops, which reset to 0.
- States are RUN, HALTING, HALTED and RESUMING. Each hart also holds a boot flag.
- Reset state: RUN if mpc_reset_run_req[h]=1. Otherwise HALTING with boot=1.
- RUN:
  - If halt_req_s=1 and halt_ack=0, go to HALTING. Halt has priority over run.
  - Else if run_req_s=1 and run_ack=0, set run_ack and stay in RUN (the hart is already running).
- HALTING: core_halt_req=1. When core_halted=1, go to HALTED, set halt_ack unless boot=1, then clear boot.
- HALTED:
  - halt_ack holds until halt_req_s=0, then clears.
  - If run_req_s=1, halt_req_s=0, halt_ack=0 and run_ack=0, go to RESUMING.
- RESUMING: core_run_req=1. When core_halted=0, go to RUN and set run_ack.
- run_ack holds until run_req_s=0, then clears. This applies in any state; a halt may begin while run_ack is still high.
- A new request is never accepted while the matching ack is still high.
- Outputs reset to 0, except core_halt_req, which resets to 1 for harts whose strap is 0.
- dec_tlu_mhartstart resets to the strap value.

## Timing
- All outputs are registered.
- SoC request edge at cycle 0 is visible as halt_req_s at cycle SYNC_STAGES. The state change and core_halt_req/core_run_req follow at cycle SYNC_STAGES+1.
- core_halted change sampled at cycle k: state and ack update at k+1.
- Ack deassertion: SYNC_STAGES+1 cycles after the SoC request drops.
- rst asserted mid-handshake: every hart returns to its strap state on the next edge. Partial acks are discarded; the SoC must restart the handshake.
- In RUN, halt_req_s and run_req_s both rising in the same cycle: the halt is serviced first. The run is serviced after halt_req drops, via HALTED → RESUMING → RUN.

## Configuration
- RV_MPC_TIMEOUT_EN defined:
  - Each hart has a counter of width $clog2(TIMEOUT_CYCLES+1). It clears on entry to HALTING or RESUMING and counts while in either state, saturating.
  - Reaching TIMEOUT_CYCLES sets mpc_timeout_err[h], which is sticky. The state is unaffected.
  - mpc_timeout_clr[h] clears the flag. If set and clear coincide, set wins.
- RV_MPC_TIMEOUT_EN undefined: no counters; mpc_timeout_err is tied to 0 and mpc_timeout_clr is ignored.

## Test plan
- Reset with strap=2'b10, NUM_HARTS=2: hart1 in RUN with mhartstart[1]=1. Hart0 has core_halt_req[0]=1; core_halted[0]=1 drives HALTED with no halt_ack[0] pulse.
- Hart0 full cycle: halt_req rises at cycle 0, so core_halt_req=1 at cycle 3. core_halted at cycle 10 gives halt_ack=1 at cycle 11. Drop halt_req: ack=0 three cycles later. run_req then drives core_run_req; core_halted=0 gives run_ack=1.
- Simultaneous halt_req and run_req in RUN: halt_ack first. run_ack asserts only after halt_req drops and the core resumes.
- run_req while in RUN: run_ack=1 at cycle SYNC_STAGES+1. No core_run_req pulse.
- rst asserted while HALTING: next cycle the hart is in its strap state with all acks 0, and is independent of the other hart.
- With RV_MPC_TIMEOUT_EN and TIMEOUT_CYCLES=16: core never halts, so mpc_timeout_err=1 after 16 cycles in HALTING. A clr pulse clears it. Without the macro the flag stays 0.

Source files
------------

// File: rtl/eh2_mpc_hart_ctrl_if.sv
// eh2_mpc_hart_ctrl_if: SoC/core MPC handshake signals for NUM_HARTS harts
interface eh2_mpc_hart_ctrl_if #(parameter int NUM_HARTS = 2);
  logic [NUM_HARTS-1:0] mpc_debug_halt_req;
  logic [NUM_HARTS-1:0] mpc_debug_run_req;
  logic [NUM_HARTS-1:0] mpc_reset_run_req;
  logic [NUM_HARTS-1:0] core_halted;
  logic [NUM_HARTS-1:0] core_halt_req;
  logic [NUM_HARTS-1:0] core_run_req;
  logic [NUM_HARTS-1:0] mpc_debug_halt_ack;
  logic [NUM_HARTS-1:0] mpc_debug_run_ack;
  logic [NUM_HARTS-1:0] dec_tlu_mhartstart;
  logic [NUM_HARTS-1:0] mpc_timeout_clr;
  logic [NUM_HARTS-1:0] mpc_timeout_err;
  modport master (
    output mpc_debug_halt_req, mpc_debug_run_req, mpc_reset_run_req, core_halted, mpc_timeout_clr,
    input  core_halt_req, core_run_req, mpc_debug_halt_ack, mpc_debug_run_ack, dec_tlu_mhartstart,
           mpc_timeout_err
  );
  modport slave (
    input  mpc_debug_halt_req, mpc_debug_run_req, mpc_reset_run_req, core_halted, mpc_timeout_clr,
    output core_halt_req, core_run_req, mpc_debug_halt_ack, mpc_debug_run_ack, dec_tlu_mhartstart,
           mpc_timeout_err
  );
endinterface

// File: rtl/eh2_mpc_hart_ctrl.sv
// eh2_mpc_hart_ctrl: per-hart MPC halt/run handshake; RV_MPC_TIMEOUT_EN adds a watchdog
module eh2_mpc_hart_ctrl #(
  parameter int NUM_HARTS      = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  eh2_mpc_hart_ctrl_if.slave bus
);
  localparam logic [1:0] RUN = 2'd0, HALTING = 2'd1, HALTED = 2'd2, RESUMING = 2'd3;
  logic [SYNC_STAGES-1:0] hsy [NUM_HARTS];
  logic [SYNC_STAGES-1:0] rsy [NUM_HARTS];
  logic [1:0] st [NUM_HARTS];
  logic [1:0] nst [NUM_HARTS];
  logic [NUM_HARTS-1:0] hs, rs, boot, nboot, hack, nhack, rack, nrack, chr, crr, mhs;
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      hs[i] = hsy[i][SYNC_STAGES-1];
      rs[i] = rsy[i][SYNC_STAGES-1];
      nst[i] = st[i];
      nboot[i] = boot[i];
      nhack[i] = hack[i] && hs[i];
      nrack[i] = rack[i] && rs[i];
      case (st[i])
        RUN:
          if (hs[i] && !hack[i]) nst[i] = HALTING;
          else if (rs[i] && !rack[i]) nrack[i] = 1'b1;
        HALTING:
          if (bus.core_halted[i]) begin
            nst[i] = HALTED;
            nhack[i] = !boot[i];
            nboot[i] = 1'b0;
          end
        HALTED:
          if (rs[i] && !hs[i] && !hack[i] && !rack[i]) nst[i] = RESUMING;
        default:
          if (!bus.core_halted[i]) begin
            nst[i] = RUN;
            nrack[i] = 1'b1;
          end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (rst) begin
        hsy[i] <= '0;
        rsy[i] <= '0;
        st[i] <= bus.mpc_reset_run_req[i] ? RUN : HALTING;
        boot[i] <= !bus.mpc_reset_run_req[i];
        hack[i] <= 1'b0;
        rack[i] <= 1'b0;
        chr[i] <= !bus.mpc_reset_run_req[i];
        crr[i] <= 1'b0;
        mhs[i] <= bus.mpc_reset_run_req[i];
      end else begin
        hsy[i] <= {hsy[i][SYNC_STAGES-2:0], bus.mpc_debug_halt_req[i]};
        rsy[i] <= {rsy[i][SYNC_STAGES-2:0], bus.mpc_debug_run_req[i]};
        st[i] <= nst[i];
        boot[i] <= nboot[i];
        hack[i] <= nhack[i];
        rack[i] <= nrack[i];
        chr[i] <= nst[i] == HALTING;
        crr[i] <= nst[i] == RESUMING;
        mhs[i] <= nst[i] == RUN;
      end
    end
  end
  assign bus.core_halt_req = chr;
  assign bus.core_run_req = crr;
  assign bus.mpc_debug_halt_ack = hack;
  assign bus.mpc_debug_run_ack = rack;
  assign bus.dec_tlu_mhartstart = mhs;
`ifdef RV_MPC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt [NUM_HARTS];
  logic [CW-1:0] ncnt [NUM_HARTS];
  logic [NUM_HARTS-1:0] busy, err;
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      busy[i] = st[i] == HALTING || st[i] == RESUMING;
      ncnt[i] = ((nst[i] == HALTING || nst[i] == RESUMING) && nst[i] != st[i]) ? '0 :
                (busy[i] && cnt[i] != TMAX) ? cnt[i] + CW'(1) : cnt[i];
    end
  end
  // a fresh expiry outranks a coincident clear
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      cnt[i] <= rst ? '0 : ncnt[i];
      err[i] <= !rst && ((busy[i] && ncnt[i] == TMAX) || (err[i] && !bus.mpc_timeout_clr[i]));
    end
  end
  assign bus.mpc_timeout_err = err;
`else
  logic unused_timeout;
  assign unused_timeout = ^{bus.mpc_timeout_clr, TIMEOUT_CYCLES[0]};
  assign bus.mpc_timeout_err = '0;
`endif
endmodule

// File: tb/tb_eh2_mpc_hart_ctrl.sv
// tb_eh2_mpc_hart_ctrl: directed scenario bench for the two-hart MPC handshake engine
module tb_eh2_mpc_hart_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  eh2_mpc_hart_ctrl_if #(.NUM_HARTS(2)) bus ();
  eh2_mpc_hart_ctrl #(.NUM_HARTS(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic resume_hart0();
    bus.mpc_debug_run_req[0] = 1'b1;
    tick(3);
    bus.core_halted[0] = 1'b0;
    tick(1);
    bus.mpc_debug_run_req[0] = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    bus.mpc_debug_halt_req = 2'b00;
    bus.mpc_debug_run_req = 2'b00;
    bus.mpc_reset_run_req = 2'b10;
    bus.core_halted = 2'b00;
    bus.mpc_timeout_clr = 2'b00;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("reset_mhartstart", bus.dec_tlu_mhartstart, 2'b10);
    chk("reset_halt_req", bus.core_halt_req, 2'b01);
    chk("reset_run_req", bus.core_run_req, 2'b00);
    chk("reset_halt_ack", bus.mpc_debug_halt_ack, 2'b00);
    chk("reset_run_ack", bus.mpc_debug_run_ack, 2'b00);
    chk("reset_timeout_err", bus.mpc_timeout_err, 2'b00);
    bus.core_halted[0] = 1'b1;
    tick(1);
    chk("boot_halted_halt_req", bus.core_halt_req, 2'b00);
    chk("boot_halted_mhartstart", bus.dec_tlu_mhartstart, 2'b10);
    for (int i = 0; i < 3; i++) chk("boot_no_halt_ack", bus.mpc_debug_halt_ack, 2'b00);
    tick(2);
    chk("boot_no_halt_ack_late", bus.mpc_debug_halt_ack, 2'b00);
  endtask

  task automatic test_full_cycle();
    bus.mpc_debug_run_req[0] = 1'b1;
    tick(2);
    chk("resume_run_req_c2", bus.core_run_req, 2'b00);
    tick(1);
    chk("resume_run_req_c3", bus.core_run_req, 2'b01);
    bus.core_halted[0] = 1'b0;
    tick(1);
    chk("resume_run_ack", bus.mpc_debug_run_ack, 2'b01);
    chk("resume_run_req_off", bus.core_run_req, 2'b00);
    chk("resume_mhartstart", bus.dec_tlu_mhartstart, 2'b11);
    bus.mpc_debug_run_req[0] = 1'b0;
    tick(2);
    chk("run_ack_hold", bus.mpc_debug_run_ack, 2'b01);
    tick(1);
    chk("run_ack_drop", bus.mpc_debug_run_ack, 2'b00);
    bus.mpc_debug_halt_req[0] = 1'b1;
    tick(2);
    chk("halt_req_c2", bus.core_halt_req, 2'b00);
    tick(1);
    chk("halt_req_c3", bus.core_halt_req, 2'b01);
    chk("halting_mhartstart", bus.dec_tlu_mhartstart, 2'b10);
    tick(7);
    chk("halt_ack_c10", bus.mpc_debug_halt_ack, 2'b00);
    bus.core_halted[0] = 1'b1;
    tick(1);
    chk("halt_ack_c11", bus.mpc_debug_halt_ack, 2'b01);
    chk("halted_halt_req_off", bus.core_halt_req, 2'b00);
    bus.mpc_debug_halt_req[0] = 1'b0;
    tick(2);
    chk("halt_ack_hold", bus.mpc_debug_halt_ack, 2'b01);
    tick(1);
    chk("halt_ack_drop", bus.mpc_debug_halt_ack, 2'b00);
  endtask

  task automatic test_simultaneous();
    resume_hart0();
    chk("simul_pre_run", bus.dec_tlu_mhartstart, 2'b11);
    bus.mpc_debug_halt_req[0] = 1'b1;
    bus.mpc_debug_run_req[0] = 1'b1;
    tick(3);
    chk("simul_halt_req", bus.core_halt_req, 2'b01);
    chk("simul_no_run_ack", bus.mpc_debug_run_ack, 2'b00);
    bus.core_halted[0] = 1'b1;
    tick(1);
    chk("simul_halt_ack", bus.mpc_debug_halt_ack, 2'b01);
    tick(4);
    chk("simul_wait_run_ack", bus.mpc_debug_run_ack, 2'b00);
    chk("simul_wait_run_req", bus.core_run_req, 2'b00);
    bus.mpc_debug_halt_req[0] = 1'b0;
    tick(3);
    chk("simul_halt_ack_drop", bus.mpc_debug_halt_ack, 2'b00);
    chk("simul_run_req_c3", bus.core_run_req, 2'b00);
    tick(1);
    chk("simul_run_req_c4", bus.core_run_req, 2'b01);
    bus.core_halted[0] = 1'b0;
    tick(1);
    chk("simul_run_ack", bus.mpc_debug_run_ack, 2'b01);
    bus.mpc_debug_run_req[0] = 1'b0;
    tick(3);
    chk("simul_run_ack_drop", bus.mpc_debug_run_ack, 2'b00);
  endtask

  task automatic test_run_in_run();
    bus.mpc_debug_run_req[1] = 1'b1;
    tick(2);
    chk("rir_ack_c2", bus.mpc_debug_run_ack, 2'b00);
    tick(1);
    chk("rir_ack_c3", bus.mpc_debug_run_ack, 2'b10);
    chk("rir_no_run_req", bus.core_run_req, 2'b00);
    tick(3);
    chk("rir_no_run_req_late", bus.core_run_req, 2'b00);
    chk("rir_mhartstart", bus.dec_tlu_mhartstart, 2'b11);
    bus.mpc_debug_run_req[1] = 1'b0;
    tick(3);
    chk("rir_ack_drop", bus.mpc_debug_run_ack, 2'b00);
  endtask

  task automatic test_reset_mid();
    bus.mpc_debug_halt_req[0] = 1'b1;
    bus.mpc_debug_run_req[1] = 1'b1;
    tick(3);
    chk("mid_halting", bus.core_halt_req, 2'b01);
    chk("mid_run_ack", bus.mpc_debug_run_ack, 2'b10);
    rst = 1'b1;
    bus.mpc_reset_run_req = 2'b01;
    tick(1);
    chk("mid_rst_halt_req", bus.core_halt_req, 2'b10);
    chk("mid_rst_mhartstart", bus.dec_tlu_mhartstart, 2'b01);
    chk("mid_rst_run_ack", bus.mpc_debug_run_ack, 2'b00);
    chk("mid_rst_halt_ack", bus.mpc_debug_halt_ack, 2'b00);
    rst = 1'b0;
    bus.mpc_debug_halt_req = 2'b00;
    bus.mpc_debug_run_req = 2'b00;
    tick(3);
    chk("mid_after_halt_req", bus.core_halt_req, 2'b10);
    chk("mid_after_acks", bus.mpc_debug_run_ack | bus.mpc_debug_halt_ack, 2'b00);
    bus.core_halted[1] = 1'b1;
    tick(1);
    chk("mid_boot_no_ack", bus.mpc_debug_halt_ack, 2'b00);
    chk("mid_boot_halted", bus.core_halt_req, 2'b00);
  endtask

  task automatic test_timeout();
    bus.mpc_debug_halt_req[0] = 1'b1;
    tick(3);
    chk("to_halting", bus.core_halt_req, 2'b01);
`ifdef RV_MPC_TIMEOUT_EN
    tick(15);
    chk("to_err_c15", bus.mpc_timeout_err, 2'b00);
    tick(1);
    chk("to_err_c16", bus.mpc_timeout_err, 2'b01);
    chk("to_still_halting", bus.core_halt_req, 2'b01);
    bus.core_halted[0] = 1'b1;
    tick(1);
    chk("to_err_sticky", bus.mpc_timeout_err, 2'b01);
    chk("to_halt_ack", bus.mpc_debug_halt_ack, 2'b01);
    bus.mpc_timeout_clr[0] = 1'b1;
    tick(1);
    bus.mpc_timeout_clr[0] = 1'b0;
    chk("to_err_cleared", bus.mpc_timeout_err, 2'b00);
    tick(2);
    chk("to_err_stays_clear", bus.mpc_timeout_err, 2'b00);
`else
    tick(20);
    chk("to_err_disabled", bus.mpc_timeout_err, 2'b00);
    chk("to_still_halting", bus.core_halt_req, 2'b01);
    bus.mpc_timeout_clr[0] = 1'b1;
    tick(1);
    bus.mpc_timeout_clr[0] = 1'b0;
    chk("to_err_disabled_clr", bus.mpc_timeout_err, 2'b00);
`endif
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_simultaneous();
    test_run_in_run();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
